// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and constants for the PWM capture block.
//   state_e       - capture FSM states (IDLE/HIGH/LOW), 2-bit encoding
//   CNT_W_DEFAULT - default counter/output width
//   sat_max()     - all-ones value for a counter of a given width
// Optional feature macro used by this block: PWM_CAPTURE_GLITCH_FILTER_EN.
package pwm_capture_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Largest value a w-bit counter can hold; counters stick here, never wrap.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control input, PWM line and measurement results.
//   en, pwm_in              - driven by the master (system / test side)
//   meas_high, meas_period  - last complete high time / period, CNT_W bits
//   meas_valid              - one-cycle strobe on each publish
//   stuck, stuck_level      - line-stopped flag and the level it stopped at
// Modports: master (drives en/pwm_in), slave (the capture block).
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             en;
  logic             pwm_in;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output en, pwm_in,
    input  meas_high, meas_period, meas_valid, stuck, stuck_level
  );

  modport slave (
    input  en, pwm_in,
    output meas_high, meas_period, meas_valid, stuck, stuck_level
  );

endinterface

// File: rtl/pwm_edge_detect.sv
// pwm_edge_detect: brings the asynchronous PWM line into the clk domain and
// produces single-cycle rise/fall pulses.
//   clk, rst - clock, synchronous active-high reset
//   pwm_in   - asynchronous PWM input
//   lvl      - clean synchronized (optionally filtered) level
//   rise     - lvl is 1 this cycle and was 0 last cycle
//   fall     - lvl is 0 this cycle and was 1 last cycle
// PWM_CAPTURE_GLITCH_FILTER_EN: adds a registered 3-sample majority filter
// after the synchronizer. Both edges get the same 2 extra cycles of delay,
// so measured widths are unaffected; 1-cycle glitches never reach lvl.
module pwm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Two older samples of sync2 plus the registered vote.
  logic s3_q, s3_d;
  logic s4_q, s4_d;
  logic filt_q, filt_d;

  always_comb begin
    s3_d   = sync2_q;
    s4_d   = s3_q;
    filt_d = (sync2_q & s3_q) | (sync2_q & s4_q) | (s3_q & s4_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q   <= 1'b0;
      s4_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s3_q   <= s3_d;
      s4_q   <= s4_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    prev_d  = lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM line in clk cycles.
// Publishes a registered period/high pair with a one-cycle valid strobe at
// every rising edge that closes a full period, and flags a line that has
// produced no rising edge for 2^CNT_W-1 cycles.
//   clk, rst - clock, synchronous active-high reset
//   bus      - pwm_capture_if.slave: en, pwm_in in; meas_high, meas_period,
//              meas_valid, stuck, stuck_level out
// Optional macro PWM_CAPTURE_GLITCH_FILTER_EN enables the input majority
// filter inside pwm_edge_detect.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic lvl, rise, fall;

  pwm_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (bus.pwm_in),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] meas_period_q, meas_period_d;
  logic [CNT_W-1:0] meas_high_q, meas_high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    high_d        = high_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!bus.en) begin
      // Abandon any partial period; results and stuck flag are kept.
      state_d  = ST_IDLE;
      period_d = '0;
      high_d   = '0;
    end else if (rise) begin
      // A rise wins over a same-cycle timeout, so a saturated period is
      // still published. From IDLE there is no complete period yet.
      if (state_q != ST_IDLE) begin
        meas_period_d = period_q;
        meas_high_d   = high_q;
        meas_valid_d  = 1'b1;
      end
      state_d  = ST_HIGH;
      period_d = CNT_ONE;
      high_d   = CNT_ONE;
      stuck_d  = 1'b0;
    end else if (period_q == CNT_MAX) begin
      // No rise for the full counter range. Also fires from IDLE, which
      // catches lines stuck at 0% or 100% duty since power-up; restarting
      // the count re-arms the check and keeps stuck_level current.
      stuck_d       = 1'b1;
      stuck_level_d = lvl;
      state_d       = ST_IDLE;
      period_d      = '0;
      high_d        = '0;
    end else begin
      // period_q < CNT_MAX here, so this cannot wrap.
      period_d = period_q + CNT_ONE;
      case (state_q)
        ST_HIGH: begin
          if (fall) state_d = ST_LOW;
          else if (high_q != CNT_MAX) high_d = high_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      high_q        <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      high_q        <= high_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign bus.meas_period = meas_period_q;
  assign bus.meas_high   = meas_high_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus for pwm_capture with a cycle-level
// reference model, a per-cycle compare process and hand-computed literal
// expectations for each scenario.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = 255;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT       = 5;   // pwm_in sample edge -> rise acted on
  localparam int GL_PUBS   = 2;
  localparam int GL_LAST_P = 10;
  localparam int GL_LAST_H = 5;
  localparam int RST_PUBS  = 1;
`else
  localparam int LAT       = 3;
  localparam int GL_PUBS   = 5;
  localparam int GL_LAST_P = 3;
  localparam int GL_LAST_H = 2;
  localparam int RST_PUBS  = 2;
`endif
  localparam int STUCK_EDGE = MAXV + LAT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(W)) bus ();
  pwm_capture #(.CNT_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  // ---------------- reference model ----------------
  // h[0] is the newest pwm_in sample; reset empties the whole input path.
  logic [7:0]   h = '0;
  int           m_per = 0, m_hi = 0, m_npub = 0;
  bit           armed = 1'b0, in_high = 1'b0;
  logic [W-1:0] m_mp = '0, m_mh = '0;
  logic         m_mv = 1'b0, m_st = 1'b0, m_sl = 1'b0;

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin
    bit lv, pv, r, f;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    lv = maj3(h[2], h[3], h[4]);
    pv = maj3(h[3], h[4], h[5]);
`else
    lv = h[1];
    pv = h[2];
`endif
    r = lv & !pv;
    f = !lv & pv;
    m_mv = 1'b0;
    if (rst) begin
      h = '0; m_per = 0; m_hi = 0; armed = 0; in_high = 0;
      m_mp = '0; m_mh = '0; m_st = 0; m_sl = 0;
    end else begin
      if (!bus.en) begin
        armed = 0; in_high = 0; m_per = 0; m_hi = 0;
      end else if (r) begin
        if (armed) begin
          m_mp = W'(m_per); m_mh = W'(m_hi); m_mv = 1'b1; m_npub++;
        end
        armed = 1; in_high = 1; m_per = 1; m_hi = 1; m_st = 0;
      end else if (m_per >= MAXV) begin
        m_st = 1; m_sl = lv; armed = 0; in_high = 0; m_per = 0; m_hi = 0;
      end else begin
        m_per++;
        if (in_high && f) in_high = 0;
        else if (in_high && m_hi < MAXV) m_hi++;
      end
      h = {h[6:0], bus.pwm_in};
    end
  end

  // ---------------- publish monitor (DUT side) ----------------
  int nval = 0, last_p = -1, last_h = -1;
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      nval++;
      last_p = int'(bus.meas_period);
      last_h = int'(bus.meas_high);
    end
  end

  // ---------------- literal expectation queue ----------------
  string lit_name [64];
  int    lit_act  [64];
  int    lit_exp  [64];
  int    lit_seq = 0;
  int    lit_done = 0;

  task automatic lit(input string nm, input int act, input int exp);
    if (lit_seq < 64) begin
      lit_name[lit_seq] = nm;
      lit_act[lit_seq]  = act;
      lit_exp[lit_seq]  = exp;
      lit_seq++;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (bus.meas_valid !== m_mv || bus.meas_period !== m_mp ||
          bus.meas_high !== m_mh || bus.stuck !== m_st || bus.stuck_level !== m_sl) begin
        miscompares++;
        $display("FAIL model t=%0t got v=%0b p=%0d h=%0d st=%0b sl=%0b want v=%0b p=%0d h=%0d st=%0b sl=%0b",
                 $time, bus.meas_valid, bus.meas_period, bus.meas_high, bus.stuck, bus.stuck_level,
                 m_mv, m_mp, m_mh, m_st, m_sl);
      end
    end
    while (lit_done < lit_seq) begin
      vectors++;
      if (lit_act[lit_done] !== lit_exp[lit_done]) begin
        miscompares++;
        $display("FAIL %s got %0d want %0d", lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      end
      lit_done++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit p, input bit e, input bit r);
    bus.pwm_in = p;
    bus.en     = e;
    rst        = r;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit p);
    cyc(p, 1'b1, 1'b1);
    cyc(p, 1'b1, 1'b1);
  endtask

  function automatic int outs_packed();
    return int'({bus.meas_valid, bus.stuck, bus.stuck_level, bus.meas_period, bus.meas_high});
  endfunction

  initial begin
    int b, mb;
    bus.pwm_in = 1'b0;
    bus.en     = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    lit("reset_outputs_zero", outs_packed(), 0);

    // T1: period 9, high 3, three periods -> two publishes of 9/3
    b = nval; mb = m_npub;
    for (int t = 0; t < 27; t++) cyc((t % 9) < 3, 1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    lit("t1_pub_count", nval - b, 2);
    lit("t1_model_pubs", m_npub - mb, 2);
    lit("t1_period", last_p, 9);
    lit("t1_high", last_h, 3);

    // T2: line held high from reset -> stuck after 255+latency edges
    do_reset(1'b1);
    b = nval;
    repeat (STUCK_EDGE - 1) cyc(1'b1, 1'b1, 1'b0);
    lit("t2_stuck_before", int'(bus.stuck), 0);
    cyc(1'b1, 1'b1, 1'b0);
    lit("t2_stuck_set", int'(bus.stuck), 1);
    lit("t2_stuck_level", int'(bus.stuck_level), 1);
    lit("t2_model_stuck", int'(m_st), 1);
    lit("t2_no_pub", nval - b, 0);
    for (int t = 0; t < 34; t++) cyc((t % 9) >= 6, 1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    lit("t2_stuck_cleared", int'(bus.stuck), 0);
    lit("t2_pub_count", nval - b, 3);
    lit("t2_period", last_p, 9);
    lit("t2_high", last_h, 3);

    // T3: en low for 2 cycles inside the second period
    do_reset(1'b0);
    b = nval; mb = m_npub;
    for (int t = 0; t < 45; t++) cyc((t % 9) < 3, !(t == 14 || t == 15), 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    lit("t3_pub_count", nval - b, 3);
    lit("t3_model_pubs", m_npub - mb, 3);
    lit("t3_period", last_p, 9);
    lit("t3_high", last_h, 3);

    // T4: period 10 high 5 with a 1-cycle low glitch in the high phase
    do_reset(1'b0);
    b = nval;
    for (int t = 0; t < 30; t++) cyc(((t % 10) < 5) && ((t % 10) != 2), 1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    lit("t4_pub_count", nval - b, GL_PUBS);
    lit("t4_period", last_p, GL_LAST_P);
    lit("t4_high", last_h, GL_LAST_H);

    // T5: 1-cycle reset in the middle of a high phase
    do_reset(1'b0);
    for (int t = 0; t < 45; t++) begin
      cyc((t % 9) < 3, 1'b1, t == 19);
      if (t == 19) begin
        lit("t5_rst_outputs_zero", outs_packed(), 0);
        b = nval;
      end
    end
    repeat (12) cyc(1'b0, 1'b1, 1'b0);
    lit("t5_pub_count", nval - b, RST_PUBS);
    lit("t5_period", last_p, 9);
    lit("t5_high", last_h, 3);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures period and high time of a single-bit PWM input, in `clk` cycles. It is the receive-side counterpart of the team's PWM generator and sits on a TinyTapeout-style user pin for loopback self-test and external PWM decoding. After each full period it publishes a registered duty/period pair with a one-cycle valid strobe. It flags lines that stop toggling.

## Interface
- `CNT_W`, default 8: width of the period and high-time counters and outputs.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  measurement enable; low forces IDLE.
- `pwm_in`  in  1  asynchronous PWM input.
- `meas_high`  out  CNT_W  high time of the last complete period.
- `meas_period`  out  CNT_W  length of the last complete period.
- `meas_valid`  out  1  one-cycle strobe when a new measurement is published.
- `stuck`  out  1  no rising edge within 2^CNT_W−1 cycles; holds until the next rising edge.
- `stuck_level`  out  1  synchronized input level when `stuck` was set.

## Operation
- Input path: 2-flop synchronizer, then a `prev` register. `rise = sync & ~prev`, `fall = ~sync & prev`.
- FSM states, encoded in 2 bits:
  - IDLE: waits for `rise`, then goes to HIGH.
  - HIGH: on `fall`, goes to LOW.
  - LOW: on `rise`, publishes and goes to HIGH.
- On every `rise` in any state with `en`=1:
  - `period_cnt` <= 1 and `high_cnt` <= 1.
  - `stuck` <= 0.
- Publishing (on `rise` in HIGH or LOW):
  - `meas_period` <= `period_cnt` and `meas_high` <= `high_cnt`.
  - `meas_valid` <= 1 for exactly one cycle.
- A `rise` in HIGH happens only after a filtered-out fall. It is still a valid period: publish it.
- `period_cnt` increments every cycle in HIGH/LOW when there is no `rise`.
- `high_cnt` increments only in HIGH when there is neither `fall` nor `rise`.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Timeout: when `period_cnt` reaches 2^CNT_W−1 in HIGH or LOW:
  - `stuck` <= 1 and `stuck_level` <= sync level.
  - FSM goes to IDLE; no `meas_valid`.
  - `meas_*` keep their last values.
- Stuck detection also runs in IDLE via `period_cnt`. It covers constant 0% and 100% duty lines from power-up.
- Simultaneous `rise` and timeout in the same cycle: the `rise` wins, and the period is published with the saturated value.
- `en` falling mid-period:
  - FSM goes to IDLE and counters clear.
  - `meas_*` and `stuck` hold; a partial period is never published.
- `en` rising: the first period is published only after two rising edges.
- `rst` mid-operation: everything returns to reset values on the next edge.

## Timing
- Reset values: `meas_high`=0, `meas_period`=0, `meas_valid`=0, `stuck`=0, `stuck_level`=0, FSM=IDLE, counters=0, synchronizer/prev=0.
- `pwm_in` rising sampled at edge k:
  - `rise` is seen during cycle k+2.
  - `meas_valid` is high in the cycle after edge k+2. Latency is 3 edges (5 with the filter).
- Measured values are exact, filter latency included: period H+L gives `meas_period`=H+L, and high time H gives `meas_high`=H.
- Minimum resolvable pulse:
  - 1 cycle without the filter.
  - 2 cycles with the filter; shorter pulses are suppressed.

## Configuration
- `PWM_CAPTURE_GLITCH_FILTER_EN` defined:
  - A 3-sample majority filter, registered, is inserted after the synchronizer.
  - Adds 2 cycles of latency to both edges, so measured widths are unchanged.
  - Single-cycle glitches are ignored.
- Undefined: there is no filter, and every synchronized transition is an edge.

## Structure
- `pwm_capture_pkg` contains:
  - the FSM state typedef (IDLE/HIGH/LOW);
  - the `CNT_W` default constant;
  - a saturation-max helper function.
- Sub-module `pwm_edge_detect` contains the synchronizer, the optional filter, the prev register and `rise`/`fall`.
- `pwm_capture` contains the FSM, counters and output registers.

## Test plan
- Period 9, duty 3 (generator with bits=3, duty=3), 3 periods → two `meas_valid` pulses after the first edge, each with `meas_period`=9 and `meas_high`=3.
- `pwm_in` held 1 from reset, `CNT_W`=8 → `stuck`=1 and `stuck_level`=1 after 255+3 cycles; no `meas_valid`. Then toggle at period 9 → `stuck` clears on the first rise.
- `en` dropped 4 cycles into a period and raised 2 cycles later → no publish for the broken period; first valid after the second rise; values are correct.
- With the filter, period 10 duty 5 plus a 1-cycle low glitch inside the high phase → `meas_high`=5 and `meas_period`=10. Without the filter → an extra publish with a shortened high time.
- `rst` asserted for 1 cycle mid-HIGH → all outputs are 0 the next cycle; the first publish comes after two further rises.
